// File: rtl/game_pkg.sv
// Game-level types shared by the flow controller, its interface and the bench.
package game_pkg;

    typedef enum logic [2:0] {
        START     = 3'd0,
        COUNTDOWN = 3'd1,
        GAME      = 3'd2,
        ROUND_END = 3'd3,
        MATCH_END = 3'd4
    } game_mode;

endpackage

// File: rtl/vga_pkg.sv
// Screen-space hit areas (inclusive pixel bounds) for the menu buttons.
package vga_pkg;

    localparam logic [11:0] PLAY_X_MIN = 12'd300;
    localparam logic [11:0] PLAY_X_MAX = 12'd500;
    localparam logic [11:0] PLAY_Y_MIN = 12'd250;
    localparam logic [11:0] PLAY_Y_MAX = 12'd350;

    localparam logic [11:0] RECT_X_MIN = 12'd350;
    localparam logic [11:0] RECT_X_MAX = 12'd450;
    localparam logic [11:0] RECT_Y_MIN = 12'd400;
    localparam logic [11:0] RECT_Y_MAX = 12'd450;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundle of pointer/collision inputs and game status outputs of game_flow_ctrl.
interface game_flow_ctrl_if #(
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned ROUNDS_TO_WIN = 3
);
    import game_pkg::*;

    localparam int unsigned SW = $clog2(ROUNDS_TO_WIN + 1);
    localparam int unsigned IW = $clog2(NUM_PLAYERS);

    logic                      mouse_left;
    logic [11:0]               xpos;
    logic [11:0]               ypos;
    logic [NUM_PLAYERS-1:0]    collision;
    game_mode                  mode;
    logic                      spawn;
    logic [NUM_PLAYERS-1:0]    alive;
    logic                      winner_valid;
    logic [IW-1:0]             winner_idx;
    logic [NUM_PLAYERS*SW-1:0] score;
    logic [7:0]                round_cnt;

    modport master (
        output mouse_left, xpos, ypos, collision,
        input  mode, spawn, alive, winner_valid, winner_idx, score, round_cnt
    );

    modport slave (
        input  mouse_left, xpos, ypos, collision,
        output mode, spawn, alive, winner_valid, winner_idx, score, round_cnt
    );

endinterface

// File: rtl/click_hit.sv
// Mouse-button rising-edge detector qualified by an inclusive rectangle test.
module click_hit #(
    parameter logic [11:0] X_MIN = 12'd0,
    parameter logic [11:0] X_MAX = 12'd0,
    parameter logic [11:0] Y_MIN = 12'd0,
    parameter logic [11:0] Y_MAX = 12'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic        hit
);

    logic prev_q;

    // Resets high so a button held through reset never counts as a click.
    always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b1;
        else     prev_q <= mouse_left;
    end

    assign hit = mouse_left & ~prev_q &
                 (xpos >= X_MIN) & (xpos <= X_MAX) &
                 (ypos >= Y_MIN) & (ypos <= Y_MAX);

endmodule

// File: rtl/game_flow_ctrl.sv
// Match/round state machine: menu clicks, countdown, survivor tracking and scoring.
module game_flow_ctrl
    import game_pkg::*;
    import vga_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS      = 2,
    parameter int unsigned ROUNDS_TO_WIN    = 3,
    parameter int unsigned COUNTDOWN_CYCLES = 65_000_000
) (
    input logic             clk,
    input logic             rst,
    game_flow_ctrl_if.slave bus
);

    localparam int unsigned SW = $clog2(ROUNDS_TO_WIN + 1);
    localparam int unsigned IW = $clog2(NUM_PLAYERS);
    localparam int unsigned CW = (COUNTDOWN_CYCLES > 1) ? $clog2(COUNTDOWN_CYCLES) : 1;

    game_mode                  state_q;
    logic                      spawn_q;
    logic [NUM_PLAYERS-1:0]    alive_q;
    logic                      win_valid_q;
    logic [IW-1:0]             win_idx_q;
    logic [NUM_PLAYERS*SW-1:0] score_q;
    logic [7:0]                round_q;
    logic [CW-1:0]             cnt_q;

    logic                   play_hit;
    logic                   rect_hit;
    logic [NUM_PLAYERS-1:0] alive_nxt;
    logic [2:0]             n_alive;
    logic [IW-1:0]          last_idx;
    logic [SW-1:0]          cur_score;
    logic [SW-1:0]          win_score;

    click_hit #(
        .X_MIN(PLAY_X_MIN), .X_MAX(PLAY_X_MAX), .Y_MIN(PLAY_Y_MIN), .Y_MAX(PLAY_Y_MAX)
    ) u_play_hit (
        .clk       (clk),
        .rst       (rst),
        .mouse_left(bus.mouse_left),
        .xpos      (bus.xpos),
        .ypos      (bus.ypos),
        .hit       (play_hit)
    );

    click_hit #(
        .X_MIN(RECT_X_MIN), .X_MAX(RECT_X_MAX), .Y_MIN(RECT_Y_MIN), .Y_MAX(RECT_Y_MAX)
    ) u_rect_hit (
        .clk       (clk),
        .rst       (rst),
        .mouse_left(bus.mouse_left),
        .xpos      (bus.xpos),
        .ypos      (bus.ypos),
        .hit       (rect_hit)
    );

    // Survivor count and the index of the highest surviving player.
    always_comb begin
        alive_nxt = alive_q & ~bus.collision;
        n_alive   = 3'd0;
        last_idx  = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive_nxt[i]) begin
                n_alive  = n_alive + 3'd1;
                last_idx = IW'(i);
            end
        end
        cur_score = score_q[last_idx*SW +: SW];
        win_score = cur_score + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= START;
            spawn_q     <= 1'b0;
            alive_q     <= '1;
            win_valid_q <= 1'b0;
            win_idx_q   <= '0;
            score_q     <= '0;
            round_q     <= 8'd0;
            cnt_q       <= '0;
        end else begin
            spawn_q <= 1'b0;
            case (state_q)
                START: begin
                    if (play_hit) begin
                        state_q     <= COUNTDOWN;
                        spawn_q     <= 1'b1;
                        alive_q     <= '1;
                        cnt_q       <= '0;
                        score_q     <= '0;
                        round_q     <= 8'd0;
                        win_valid_q <= 1'b0;
                    end
                end
                COUNTDOWN: begin
                    if (cnt_q == CW'(COUNTDOWN_CYCLES - 1)) begin
                        state_q <= GAME;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                GAME: begin
                    alive_q <= alive_nxt;
                    if (n_alive <= 3'd1) begin
                        if (round_q != 8'hFF) round_q <= round_q + 8'd1;
                        if (n_alive == 3'd1) begin
                            win_valid_q <= 1'b1;
                            win_idx_q   <= last_idx;
                            if (cur_score < SW'(ROUNDS_TO_WIN)) begin
                                score_q[last_idx*SW +: SW] <= win_score;
                            end
                            state_q <= (win_score == SW'(ROUNDS_TO_WIN)) ? MATCH_END : ROUND_END;
                        end else begin
                            win_valid_q <= 1'b0;
                            state_q     <= ROUND_END;
                        end
                    end
                end
                ROUND_END: begin
                    if (rect_hit) begin
                        state_q <= COUNTDOWN;
                        spawn_q <= 1'b1;
                        alive_q <= '1;
                        cnt_q   <= '0;
                    end
                end
                MATCH_END: begin
                    if (rect_hit) state_q <= START;
                end
                default: state_q <= START;
            endcase
        end
    end

    assign bus.mode         = state_q;
    assign bus.spawn        = spawn_q;
    assign bus.alive        = alive_q;
    assign bus.winner_valid = win_valid_q;
    assign bus.winner_idx   = win_idx_q;
    assign bus.score        = score_q;
    assign bus.round_cnt    = round_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed scoreboard bench for game_flow_ctrl with 3 players, 2 wins per match.
module tb_game_flow_ctrl;
    import game_pkg::*;
    import vga_pkg::*;

    typedef struct {
        int         cyc;
        string      name;
        game_mode   mode;
        logic       spawn;
        logic [2:0] alive;
        logic       wv;
        logic [1:0] widx;
        logic [5:0] score;
        logic [7:0] rc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    game_flow_ctrl_if #(.NUM_PLAYERS(3), .ROUNDS_TO_WIN(2)) gif ();

    game_flow_ctrl #(
        .NUM_PLAYERS(3), .ROUNDS_TO_WIN(2), .COUNTDOWN_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(gif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input string nm, input game_mode m, input logic sp,
                            input logic [2:0] al, input logic wv, input logic [1:0] wi,
                            input logic [5:0] sc, input logic [7:0] rc);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.mode = m; e.spawn = sp; e.alive = al;
        e.wv = wv; e.widx = wi; e.score = sc; e.rc = rc;
        sb.push_back(e);
    endtask

    task automatic push_reset(input string nm);
        push_exp(nm, START, 1'b0, 3'b111, 1'b0, 2'd0, 6'h00, 8'd0);
    endtask

    // Press at (x,y) so it is sampled on the next edge; caller releases later.
    task automatic click(input logic [11:0] x, input logic [11:0] y);
        gif.xpos = x;
        gif.ypos = y;
        gif.mouse_left = 1'b1;
        step(1);
    endtask

    task automatic release_btn();
        gif.mouse_left = 1'b0;
        step(1);
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (gif.mode !== mon_e.mode || gif.spawn !== mon_e.spawn ||
                gif.alive !== mon_e.alive || gif.winner_valid !== mon_e.wv ||
                gif.winner_idx !== mon_e.widx || gif.score !== mon_e.score ||
                gif.round_cnt !== mon_e.rc) begin
                n_errors++;
                $display("FAIL %s: got mode=%0d spawn=%b alive=%b wv=%b idx=%0d score=%h rc=%0d, want mode=%0d spawn=%b alive=%b wv=%b idx=%0d score=%h rc=%0d",
                         mon_e.name, gif.mode, gif.spawn, gif.alive, gif.winner_valid,
                         gif.winner_idx, gif.score, gif.round_cnt, mon_e.mode, mon_e.spawn,
                         mon_e.alive, mon_e.wv, mon_e.widx, mon_e.score, mon_e.rc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, want finish before 200000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        gif.mouse_left = 1'b0;
        gif.xpos = 12'd0;
        gif.ypos = 12'd0;
        gif.collision = 3'b000;
        step(2);
        push_reset("reset");
        rst = 1'b0;
        step(1);

        // Start match, countdown of 8 cycles, collisions ignored meanwhile
        click(PLAY_X_MIN, PLAY_Y_MIN);
        push_exp("cd_entry", COUNTDOWN, 1'b1, 3'b111, 1'b0, 2'd0, 6'h00, 8'd0);
        release_btn();
        push_exp("cd_spawn_off", COUNTDOWN, 1'b0, 3'b111, 1'b0, 2'd0, 6'h00, 8'd0);
        gif.collision = 3'b111;
        step(5);
        push_exp("cd_collide", COUNTDOWN, 1'b0, 3'b111, 1'b0, 2'd0, 6'h00, 8'd0);
        gif.collision = 3'b000;
        step(1);
        push_exp("cd_last", COUNTDOWN, 1'b0, 3'b111, 1'b0, 2'd0, 6'h00, 8'd0);
        step(1);
        push_exp("game_entry", GAME, 1'b0, 3'b111, 1'b0, 2'd0, 6'h00, 8'd0);

        // Player 0 then player 1 crash (p0 again, already dead) -> player 2 wins
        gif.collision = 3'b001;
        step(1);
        push_exp("p0_dead", GAME, 1'b0, 3'b110, 1'b0, 2'd0, 6'h00, 8'd0);
        gif.collision = 3'b011;
        step(1);
        push_exp("p2_wins", ROUND_END, 1'b0, 3'b100, 1'b1, 2'd2, 6'h10, 8'd1);
        gif.collision = 3'b000;

        click(PLAY_X_MIN, PLAY_Y_MIN);
        push_exp("re_outside", ROUND_END, 1'b0, 3'b100, 1'b1, 2'd2, 6'h10, 8'd1);
        release_btn();

        // Round 2: draw
        click(RECT_X_MIN, RECT_Y_MAX);
        push_exp("re_to_cd", COUNTDOWN, 1'b1, 3'b111, 1'b1, 2'd2, 6'h10, 8'd1);
        release_btn();
        step(7);
        push_exp("cd2_game", GAME, 1'b0, 3'b111, 1'b1, 2'd2, 6'h10, 8'd1);
        gif.collision = 3'b111;
        step(1);
        push_exp("draw", ROUND_END, 1'b0, 3'b000, 1'b0, 2'd2, 6'h10, 8'd2);
        gif.collision = 3'b000;

        // Round 3: player 0 wins
        click(RECT_X_MAX, RECT_Y_MIN);
        push_exp("re_to_cd2", COUNTDOWN, 1'b1, 3'b111, 1'b0, 2'd2, 6'h10, 8'd2);
        release_btn();
        step(7);
        gif.collision = 3'b110;
        step(1);
        push_exp("p0_win1", ROUND_END, 1'b0, 3'b001, 1'b1, 2'd0, 6'h11, 8'd3);
        gif.collision = 3'b000;

        // Round 4: player 0 reaches two wins -> match over
        click(RECT_X_MIN, RECT_Y_MIN);
        release_btn();
        step(7);
        gif.collision = 3'b110;
        step(1);
        push_exp("p0_match", MATCH_END, 1'b0, 3'b001, 1'b1, 2'd0, 6'h12, 8'd4);
        gif.collision = 3'b000;

        click(RECT_X_MAX + 12'd1, RECT_Y_MIN);
        push_exp("me_outside", MATCH_END, 1'b0, 3'b001, 1'b1, 2'd0, 6'h12, 8'd4);
        release_btn();
        click(RECT_X_MAX, RECT_Y_MAX);
        push_exp("me_to_start", START, 1'b0, 3'b001, 1'b1, 2'd0, 6'h12, 8'd4);
        release_btn();
        click(PLAY_X_MAX + 12'd1, PLAY_Y_MAX);
        push_exp("start_outside", START, 1'b0, 3'b001, 1'b1, 2'd0, 6'h12, 8'd4);
        release_btn();
        click(PLAY_X_MAX, PLAY_Y_MAX);
        push_exp("new_match", COUNTDOWN, 1'b1, 3'b111, 1'b0, 2'd0, 6'h00, 8'd0);
        release_btn();
        step(7);

        // Reset mid-GAME while a winning collision is presented
        gif.collision = 3'b001;
        step(1);
        push_exp("g_before_rst", GAME, 1'b0, 3'b110, 1'b0, 2'd0, 6'h00, 8'd0);
        gif.collision = 3'b010;
        rst = 1'b1;
        step(1);
        push_reset("rst_mid_game");
        gif.collision = 3'b000;
        rst = 1'b0;
        step(1);

        // Reset mid-COUNTDOWN
        click(PLAY_X_MIN, PLAY_Y_MAX);
        release_btn();
        step(3);
        rst = 1'b1;
        step(1);
        push_reset("rst_mid_cd");

        // Button held through reset: no click until released and pressed again
        gif.xpos = PLAY_X_MIN;
        gif.ypos = PLAY_Y_MIN;
        gif.mouse_left = 1'b1;
        step(1);
        rst = 1'b0;
        step(20);
        push_reset("held_no_click");
        gif.mouse_left = 1'b0;
        step(1);
        gif.mouse_left = 1'b1;
        step(1);
        push_exp("repress", COUNTDOWN, 1'b1, 3'b111, 1'b0, 2'd0, 6'h00, 8'd0);
        gif.mouse_left = 1'b0;
        step(2);

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
